// File: rtl/jogo_pkg.sv
// Shared definitions for the memory game: state codes shown on the debug
// 7-segment digit and default presentation timings.
package jogo_pkg;

    // 4-bit codes so db_estado can drive hexa7seg directly
    typedef enum logic [3:0] {
        INICIAL = 4'h0,
        PREPARA = 4'h1,
        BUSCA   = 4'h2,
        ACENDE  = 4'h3,
        APAGA   = 4'h4,
        PROXIMO = 4'h5,
        FIM     = 4'hF
    } estado_t;

    localparam int unsigned T_ON_PADRAO  = 1000;
    localparam int unsigned T_OFF_PADRAO = 500;

endpackage

// File: rtl/temporizador_mostra.sv
// Up-counter timing the lit and dark phases of each displayed word.
// Synchronous clear has priority over enable; the count saturates at all-ones.
module temporizador_mostra #(
    parameter int unsigned T_ON  = 1000,
    parameter int unsigned T_OFF = 500
) (
    input  logic clock,
    input  logic reset,
    input  logic limpa,
    input  logic conta,
    output logic fim_on,
    output logic fim_off
);

    localparam int unsigned T_MAX = (T_ON > T_OFF) ? T_ON : T_OFF;
    localparam int unsigned W     = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    logic [W-1:0] cont_q, cont_d;

    // Next count: clear, saturating increment, or hold
    always_comb begin
        cont_d = cont_q;
        if (limpa) begin
            cont_d = '0;
        end else if (conta && (cont_q != '1)) begin
            cont_d = cont_q + W'(1);
        end
    end

    // Count register with asynchronous active-low reset
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cont_q <= '0;
        end else begin
            cont_q <= cont_d;
        end
    end

    assign fim_on  = (cont_q == W'(T_ON - 1));
    assign fim_off = (cont_q == W'(T_OFF - 1));

endmodule

// File: rtl/mostra_sequencia.sv
// Plays the stored game sequence on the LEDs: each word from address 0 up to
// the latched limit is lit for T_ON clocks followed by T_OFF dark clocks,
// then pronto pulses for one cycle.
module mostra_sequencia
    import jogo_pkg::*;
#(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 4,
    parameter int unsigned T_ON   = T_ON_PADRAO,
    parameter int unsigned T_OFF  = T_OFF_PADRAO
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar,
    input  logic [ADDR_W-1:0] limite,
    input  logic [DATA_W-1:0] mem_dado,
    output logic [ADDR_W-1:0] mem_endereco,
    output logic [DATA_W-1:0] leds,
    output logic              mostrando,
    output logic              pronto,
    output logic [3:0]        db_estado
);

    estado_t           estado_q;
    logic [ADDR_W-1:0] end_q;
    logic [ADDR_W-1:0] limite_q;
    logic [DATA_W-1:0] leds_q;
    logic              mostrando_q;
    logic              pronto_q;

    logic conta, limpa;
    logic fim_on, fim_off;

    temporizador_mostra #(
        .T_ON (T_ON),
        .T_OFF(T_OFF)
    ) u_temporizador (
        .clock  (clock),
        .reset  (reset),
        .limpa  (limpa),
        .conta  (conta),
        .fim_on (fim_on),
        .fim_off(fim_off)
    );

    // Timer runs only inside a lit/dark phase; it is cleared on the phase's
    // final cycle and in every other state, so each phase starts from zero
    always_comb begin
        conta = 1'b0;
        case (estado_q)
            ACENDE:  conta = !fim_on;
            APAGA:   conta = !fim_off;
            default: conta = 1'b0;
        endcase
    end

    assign limpa = !conta;

    // Presentation FSM with registered address, LED, status and pulse outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q    <= INICIAL;
            end_q       <= '0;
            limite_q    <= '0;
            leds_q      <= '0;
            mostrando_q <= 1'b0;
            pronto_q    <= 1'b0;
        end else begin
            pronto_q <= 1'b0;
            case (estado_q)
                INICIAL: begin
                    leds_q <= '0;
                    if (iniciar) begin
                        estado_q    <= PREPARA;
                        mostrando_q <= 1'b1;
                    end
                end
                PREPARA: begin
                    end_q    <= '0;
                    limite_q <= limite;
                    estado_q <= BUSCA;
                end
                BUSCA: begin
                    leds_q   <= mem_dado;
                    estado_q <= ACENDE;
                end
                ACENDE: begin
                    if (fim_on) begin
                        leds_q   <= '0;
                        estado_q <= APAGA;
                    end
                end
                APAGA: begin
                    if (fim_off) begin
                        // Limit check precedes the increment, so the address never wraps
                        if (end_q == limite_q) begin
                            estado_q    <= FIM;
                            mostrando_q <= 1'b0;
                            pronto_q    <= 1'b1;
                        end else begin
                            estado_q <= PROXIMO;
                        end
                    end
                end
                PROXIMO: begin
                    end_q    <= end_q + ADDR_W'(1);
                    estado_q <= BUSCA;
                end
                FIM: begin
                    estado_q <= INICIAL;
                end
                default: begin
                    estado_q    <= INICIAL;
                    mostrando_q <= 1'b0;
                end
            endcase
        end
    end

    assign mem_endereco = end_q;
    assign leds         = leds_q;
    assign mostrando    = mostrando_q;
    assign pronto       = pronto_q;
    assign db_estado    = estado_q;

endmodule

// File: tb/tb_mostra_sequencia.sv
// Self-checking bench for mostra_sequencia with T_ON=4, T_OFF=2 and a small ROM.
// Expected outputs are derived from the presentation timeline arithmetic.
module tb_mostra_sequencia;

    localparam int TON  = 4;
    localparam int TOFF = 2;
    localparam int PER  = 1 + TON + TOFF + 1;

    logic       clock = 1'b0;
    logic       reset;
    logic       iniciar;
    logic [3:0] limite;
    logic [3:0] mem_dado;
    logic [3:0] mem_endereco;
    logic [3:0] leds;
    logic       mostrando;
    logic       pronto;
    logic [3:0] db_estado;

    logic [3:0] rom [16];

    int n_tests = 0;
    int n_fail  = 0;
    int ult_end = 0;

    always #5 clock = ~clock;

    assign mem_dado = rom[mem_endereco];

    mostra_sequencia #(
        .ADDR_W(4),
        .DATA_W(4),
        .T_ON  (TON),
        .T_OFF (TOFF)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .iniciar     (iniciar),
        .limite      (limite),
        .mem_dado    (mem_dado),
        .mem_endereco(mem_endereco),
        .leds        (leds),
        .mostrando   (mostrando),
        .pronto      (pronto),
        .db_estado   (db_estado)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic passo;
        @(posedge clock);
        #1;
    endtask

    // Idle expectation: waiting for a start, address left where the last run ended
    task automatic confere_ocioso(input string tag);
        chk({tag, " db"},   32'(db_estado),    32'h0);
        chk({tag, " leds"}, 32'(leds),         32'h0);
        chk({tag, " most"}, 32'(mostrando),    32'h0);
        chk({tag, " pr"},   32'(pronto),       32'h0);
        chk({tag, " end"},  32'(mem_endereco), 32'(ult_end));
    endtask

    // Expected outputs k cycles after the edge that accepted the start.
    // Timeline: 1 prep cycle, then per word: fetch, TON lit, TOFF dark,
    // one step cycle (omitted after the last word), then the done cycle.
    task automatic confere_ciclo(input int k, input int L, input int ant);
        int total, j, w, r;
        int e_db, e_leds, e_most, e_pr, e_end;
        string t;
        total = 1 + (L + 1) * (1 + TON + TOFF) + L;
        e_leds = 0; e_most = 1; e_pr = 0;
        if (k == 0) begin
            e_db = 1; e_end = ant;
        end else if (k == total) begin
            e_db = 15; e_end = L; e_most = 0; e_pr = 1;
        end else begin
            j = k - 1; w = j / PER; r = j % PER;
            e_end = w;
            if (r == 0) e_db = 2;
            else if (r <= TON) begin e_db = 3; e_leds = int'(rom[w]); end
            else if (r <= TON + TOFF) e_db = 4;
            else e_db = 5;
        end
        t = $sformatf("L%0d k%0d", L, k);
        chk({t, " db"},   32'(db_estado),    32'(e_db));
        chk({t, " leds"}, 32'(leds),         32'(e_leds));
        chk({t, " most"}, 32'(mostrando),    32'(e_most));
        chk({t, " pr"},   32'(pronto),       32'(e_pr));
        chk({t, " end"},  32'(mem_endereco), 32'(e_end));
    endtask

    // One full presentation starting from an idle cycle; limite may be
    // disturbed at cycle chg_k (>=1) to show the latched value is used
    task automatic mostra(input int L, input bit segura, input int chg_k, input logic [3:0] chg_v);
        int total;
        total = 1 + (L + 1) * (1 + TON + TOFF) + L;
        iniciar = 1'b1;
        limite  = 4'(L);
        passo();
        for (int k = 0; k <= total; k++) begin
            confere_ciclo(k, L, ult_end);
            if (!segura) iniciar = 1'b0;
            if (k >= 1 && k == chg_k) limite = chg_v;
            if (k >= 1 && !segura) iniciar = ($urandom_range(0, 3) == 0);
            if (k == total) iniciar = segura;
            passo();
        end
        ult_end = L;
        confere_ocioso($sformatf("pos L%0d", L));
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = 4'b1111;
        rom[0] = 4'b0001; rom[1] = 4'b0010; rom[2] = 4'b0100; rom[3] = 4'b1000;

        reset = 1'b0; iniciar = 1'b0; limite = '0;
        #3;
        confere_ocioso("reset");
        #14 reset = 1'b1;
        passo();
        confere_ocioso("ocioso0");
        passo();
        confere_ocioso("ocioso1");

        mostra(3, 1'b0, -1, 4'h0);
        passo();
        confere_ocioso("ocioso2");
        mostra(0, 1'b0, -1, 4'h0);
        mostra(15, 1'b0, -1, 4'h0);
        passo();
        // iniciar held and limite disturbed; restart follows the idle cycle
        mostra(3, 1'b1, 5, 4'h1);
        mostra(1, 1'b0, -1, 4'h0);

        // Asynchronous abort while word 2 (0100) is lit
        iniciar = 1'b1; limite = 4'd3;
        passo();
        for (int k = 0; k <= 1 + 2 * PER + 2; k++) begin
            confere_ciclo(k, 3, ult_end);
            iniciar = 1'b0;
            if (k < 1 + 2 * PER + 2) passo();
        end
        #2 reset = 1'b0;
        #1;
        ult_end = 0;
        confere_ocioso("abort");
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            passo();
            confere_ocioso($sformatf("pos_abort%0d", i));
        end

        for (int n = 0; n < 10; n++) begin
            int L;
            L = int'($urandom_range(0, 15));
            mostra(L, 1'b0, int'($urandom_range(1, 40)), 4'($urandom));
            repeat ($urandom_range(0, 2)) begin
                passo();
                confere_ocioso("ocioso_r");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
